// File: rtl/tpu_int_ctrl.sv
// tpu_int_ctrl: interrupt controller for the TPU's interrupt sources.
// SYS_CLK   - sole clock, rising edge
// RSTTPU_N  - asynchronous active-low reset
// INT_SRC   - level interrupt lines, a rising edge is an event (bit 0 = timer TPUINT)
// INT_MSK   - 1 = source masked (kept pending, not forwarded)
// INT_ACK   - single-cycle CPU acknowledge of the current request
// MISS_CLR  - synchronous clear of MISS_CNT
// CPU_INTR  - interrupt request to the CPU
// INT_VEC   - index of the source being requested
// PENDING   - registered pending bits
// MISS_CNT  - saturating count of cycles that lost one or more events
module tpu_int_ctrl #(
    parameter int N_SRC = 4,
    parameter int CNT_W = 8
) (
    input  logic                     SYS_CLK,
    input  logic                     RSTTPU_N,
    input  logic [N_SRC-1:0]         INT_SRC,
    input  logic [N_SRC-1:0]         INT_MSK,
    input  logic                     INT_ACK,
    input  logic                     MISS_CLR,
    output logic                     CPU_INTR,
    output logic [$clog2(N_SRC)-1:0] INT_VEC,
    output logic [N_SRC-1:0]         PENDING,
    output logic [CNT_W-1:0]         MISS_CNT
);
    localparam int VW = $clog2(N_SRC);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] GAP  = 2'd2;
    logic [1:0]       r_state;
    logic [N_SRC-1:0] r_prev;
    logic [N_SRC-1:0] r_pend;
    logic [VW-1:0]    r_vec;
    logic [CNT_W-1:0] r_cnt;
    logic [N_SRC-1:0] w_evt;
    logic [N_SRC-1:0] w_clr;
    logic [N_SRC-1:0] w_elig;
    logic [VW-1:0]    w_lo;
    logic             w_ack;
    logic             w_miss;
    assign w_evt  = INT_SRC & ~r_prev;
    assign w_ack  = (r_state == REQ) && INT_ACK;
    assign w_clr  = w_ack ? (N_SRC'(1) << r_vec) : '0;
    assign w_elig = r_pend & ~INT_MSK;
    // a same-cycle ack of the bit re-arms it via the set, so it is not a miss
    assign w_miss = |(w_evt & r_pend & ~w_clr);
    always_comb begin
        w_lo = '0;
        for (int i = N_SRC - 1; i >= 0; i--)
            if (w_elig[i]) w_lo = VW'(i);
    end
    always_ff @(posedge SYS_CLK or negedge RSTTPU_N) begin
        if (!RSTTPU_N) begin
            r_state <= IDLE;
            r_prev  <= '0;
            r_pend  <= '0;
            r_vec   <= '0;
            r_cnt   <= '0;
        end else begin
            r_prev <= INT_SRC;
            r_pend <= (r_pend & ~w_clr) | w_evt;
            r_cnt  <= MISS_CLR ? CNT_W'(w_miss) :
                      (w_miss && !(&r_cnt)) ? r_cnt + CNT_W'(1) : r_cnt;
            case (r_state)
                IDLE: if (|w_elig) begin
                    r_vec   <= w_lo;
                    r_state <= REQ;
                end
                REQ:     if (INT_ACK) r_state <= GAP;
                default: r_state <= IDLE;
            endcase
        end
    end
    assign CPU_INTR = (r_state == REQ);
    assign INT_VEC  = r_vec;
    assign PENDING  = r_pend;
    assign MISS_CNT = r_cnt;
endmodule

// File: tb/tb_tpu_int_ctrl.sv
// tb_tpu_int_ctrl: directed-vector bench for tpu_int_ctrl (N_SRC=4, CNT_W=2).
module tb_tpu_int_ctrl;
    logic       SYS_CLK = 0;
    logic       RSTTPU_N = 0;
    logic [3:0] INT_SRC = '0;
    logic [3:0] INT_MSK = '0;
    logic       INT_ACK = 0;
    logic       MISS_CLR = 0;
    logic       CPU_INTR;
    logic [1:0] INT_VEC;
    logic [3:0] PENDING;
    logic [1:0] MISS_CNT;
    int         n_vec = 0;
    int         n_err = 0;

    tpu_int_ctrl #(.N_SRC(4), .CNT_W(2)) dut (
        .SYS_CLK(SYS_CLK), .RSTTPU_N(RSTTPU_N), .INT_SRC(INT_SRC),
        .INT_MSK(INT_MSK), .INT_ACK(INT_ACK), .MISS_CLR(MISS_CLR),
        .CPU_INTR(CPU_INTR), .INT_VEC(INT_VEC), .PENDING(PENDING),
        .MISS_CNT(MISS_CNT)
    );

    always #5 SYS_CLK = ~SYS_CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge SYS_CLK);
        #1;
    endtask

    initial begin
        #2;
        chk("rst_intr", CPU_INTR, 0);
        chk("rst_vec", INT_VEC, 0);
        chk("rst_pend", PENDING, 0);
        chk("rst_cnt", MISS_CNT, 0);
        step();
        step();
        RSTTPU_N = 1;
        step();
        chk("idle_intr", CPU_INTR, 0);

        // single event on the timer source
        INT_SRC = 4'b0001;
        step();
        chk("t1_pend", PENDING, 4'b0001);
        chk("t1_intr_k", CPU_INTR, 0);
        step();
        chk("t1_intr", CPU_INTR, 1);
        chk("t1_vec", INT_VEC, 0);
        INT_ACK = 1;
        step();
        INT_ACK = 0;
        chk("t1_ack_pend", PENDING, 4'b0000);
        chk("t1_gap_intr", CPU_INTR, 0);
        INT_SRC = 4'b0000;
        step();

        // simultaneous events, lowest index first, GAP between requests
        INT_SRC = 4'b0110;
        step();
        chk("t2_pend", PENDING, 4'b0110);
        step();
        chk("t2_intr1", CPU_INTR, 1);
        chk("t2_vec1", INT_VEC, 1);
        INT_ACK = 1;
        step();
        INT_ACK = 0;
        chk("t2_gap", CPU_INTR, 0);
        chk("t2_pend_ack", PENDING, 4'b0100);
        step();
        chk("t2_idle", CPU_INTR, 0);
        step();
        chk("t2_intr2", CPU_INTR, 1);
        chk("t2_vec2", INT_VEC, 2);
        INT_ACK = 1;
        step();
        INT_ACK = 0;
        INT_SRC = 4'b0000;
        step();
        chk("t2_pend_end", PENDING, 4'b0000);

        // masked source stays pending, request after unmasking
        INT_MSK = 4'b0001;
        INT_SRC = 4'b0001;
        step();
        chk("t3_pend", PENDING, 4'b0001);
        step();
        step();
        chk("t3_masked", CPU_INTR, 0);
        INT_MSK = 4'b0000;
        step();
        step();
        chk("t3_unmask", CPU_INTR, 1);
        chk("t3_vec", INT_VEC, 0);
        INT_ACK = 1;
        step();
        INT_ACK = 0;
        INT_SRC = 4'b0000;
        step();

        // miss counting on a masked (never acked) source, CNT_W=2 saturation
        INT_MSK = 4'b1000;
        INT_SRC = 4'b1000;
        step();
        chk("t4_set", MISS_CNT, 0);
        INT_SRC = 4'b0000; step(); INT_SRC = 4'b1000; step();
        chk("t4_m1", MISS_CNT, 1);
        INT_SRC = 4'b0000; step(); INT_SRC = 4'b1000; step();
        chk("t4_m2", MISS_CNT, 2);
        INT_SRC = 4'b0000; step(); INT_SRC = 4'b1000; step();
        chk("t4_m3", MISS_CNT, 3);
        INT_SRC = 4'b0000; step(); INT_SRC = 4'b1000; step();
        chk("t4_sat", MISS_CNT, 3);
        MISS_CLR = 1;
        step();
        MISS_CLR = 0;
        chk("t4_clr", MISS_CNT, 0);
        INT_SRC = 4'b0000; step();
        INT_SRC = 4'b1000;
        MISS_CLR = 1;
        step();
        MISS_CLR = 0;
        chk("t4_clr_miss", MISS_CNT, 1);
        MISS_CLR = 1;
        step();
        MISS_CLR = 0;
        chk("t4_clr2", MISS_CNT, 0);

        // event and ack on the same bit: set wins, no miss, new request after GAP
        INT_SRC = 4'b1001;
        step();
        step();
        chk("t5_intr", CPU_INTR, 1);
        INT_SRC = 4'b1000;
        step();
        INT_SRC = 4'b1001;
        INT_ACK = 1;
        step();
        INT_ACK = 0;
        chk("t5_pend", PENDING, 4'b1001);
        chk("t5_cnt", MISS_CNT, 0);
        chk("t5_gap", CPU_INTR, 0);
        step();
        chk("t5_idle", CPU_INTR, 0);
        step();
        chk("t5_rereq", CPU_INTR, 1);
        chk("t5_vec", INT_VEC, 0);

        // asynchronous reset in REQ, then source already high at release
        RSTTPU_N = 0;
        #1;
        chk("t6_async_intr", CPU_INTR, 0);
        chk("t6_async_pend", PENDING, 0);
        INT_SRC = 4'b0001;
        INT_MSK = 4'b0000;
        step();
        #2;
        RSTTPU_N = 1;
        #1;
        chk("t6_rel_intr", CPU_INTR, 0);
        chk("t6_rel_vec", INT_VEC, 0);
        chk("t6_rel_pend", PENDING, 0);
        chk("t6_rel_cnt", MISS_CNT, 0);
        step();
        chk("t6_first_evt", PENDING, 4'b0001);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
